md_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the execute stage. It accepts one operation per `start` pulse, holds `busy` for a fixed, parameter-set number of cycles, then commits the result to HI/LO. The pipeline stalls any HI/LO-touching instruction while `busy` or `start` is high. It sits beside the combinational ALU and generalises datapath width and latency.

---
 rtl/md_unit.sv | 180 ++++++++++++++++++
 tb/tb_md_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
//
// Parameters:
//   WIDTH        operand and HI/LO width
//   MULT_CYCLES  busy duration for MULT/MULTU (>= 1)
//   DIV_CYCLES   busy duration for DIV/DIVU (>= 1)
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    launch the operation on op this cycle (ignored while busy)
//   op       0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   in1      rs operand (multiplicand / dividend / MTHI-MTLO data)
//   in2      rt operand (multiplier / divisor)
//   busy     operation in flight
//   done     one-cycle pulse in the cycle after the HI/LO commit
//   hi, lo   architectural HI/LO registers
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
  logic             p_wr_q, p_wr_d;
  logic             done_q, done_d;

  // Multiply datapath: the low 2*WIDTH bits of a product of sign-extended
  // operands equal the signed product.
  logic [2*WIDTH-1:0] ext_a_s, ext_b_s, ext_a_u, ext_b_u;
  logic [2*WIDTH-1:0] prod_s, prod_u;

  assign ext_a_s = {{WIDTH{in1[WIDTH-1]}}, in1};
  assign ext_b_s = {{WIDTH{in2[WIDTH-1]}}, in2};
  assign ext_a_u = {{WIDTH{1'b0}}, in1};
  assign ext_b_u = {{WIDTH{1'b0}}, in2};
  assign prod_s  = ext_a_s * ext_b_s;
  assign prod_u  = ext_a_u * ext_b_u;

  // Divide datapath: sign-magnitude. Min-int / -1 falls out naturally as
  // quotient min-int, remainder 0. A zero divisor is replaced by 1 only to
  // keep the operator well defined; its result is never committed.
  logic             div_nz, neg_a, neg_b;
  logic [WIDTH-1:0] div_b, abs_a, abs_b, uquo, urem;
  logic [WIDTH-1:0] quo_s, rem_s, quo_u, rem_u;

  assign div_nz = (in2 != '0);
  assign div_b  = div_nz ? in2 : WIDTH'(1);
  assign neg_a  = in1[WIDTH-1];
  assign neg_b  = div_b[WIDTH-1];
  assign abs_a  = neg_a ? (WIDTH'(0) - in1) : in1;
  assign abs_b  = neg_b ? (WIDTH'(0) - div_b) : div_b;
  assign uquo   = abs_a / abs_b;
  assign urem   = abs_a % abs_b;
  assign quo_s  = (neg_a ^ neg_b) ? (WIDTH'(0) - uquo) : uquo;
  assign rem_s  = neg_a ? (WIDTH'(0) - urem) : urem;
  assign quo_u  = in1 / div_b;
  assign rem_u  = in1 % div_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_wr_d  = p_wr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult: begin
              p_hi_d  = prod_s[2*WIDTH-1:WIDTH];
              p_lo_d  = prod_s[WIDTH-1:0];
              p_wr_d  = 1'b1;
              cnt_d   = MultLoad;
              state_d = StRun;
            end
            OpMultu: begin
              p_hi_d  = prod_u[2*WIDTH-1:WIDTH];
              p_lo_d  = prod_u[WIDTH-1:0];
              p_wr_d  = 1'b1;
              cnt_d   = MultLoad;
              state_d = StRun;
            end
            OpDiv: begin
              p_hi_d  = rem_s;
              p_lo_d  = quo_s;
              p_wr_d  = div_nz;
              cnt_d   = DivLoad;
              state_d = StRun;
            end
            OpDivu: begin
              p_hi_d  = rem_u;
              p_lo_d  = quo_u;
              p_wr_d  = div_nz;
              cnt_d   = DivLoad;
              state_d = StRun;
            end
            OpMthi:  hi_d = in1;
            OpMtlo:  lo_d = in1;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntOne;
        // Count reaches zero at this edge: commit and return to idle.
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (p_wr_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_wr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_wr_q  <= p_wr_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with a behavioural HI/LO model.
module tb_md_unit;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  md_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural reference: what HI/LO must hold after an accepted operation.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin
        sp = longint'(sa) * longint'(sb);
        exp_hi = sp[63:32];
        exp_lo = sp[31:0];
      end
      3'd1: begin
        up = longint'({32'h0, a}) * longint'({32'h0, b});
        exp_hi = up[63:32];
        exp_lo = up[31:0];
      end
      3'd2: begin
        if (b == 0) begin
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_lo = 32'h8000_0000;
          exp_hi = 32'h0;
        end else begin
          exp_lo = sa / sb;
          exp_hi = sa % sb;
        end
      end
      3'd3: begin
        if (b != 0) begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_cycles(input logic [2:0] o);
    if (o <= 3'd1) return MultN;
    if (o <= 3'd3) return DivN;
    return 0;
  endfunction

  // Issues one operation and observes busy/done until three idle samples.
  // dpos is the sample index (0 = first cycle after the start edge) of done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bc, output int dc, output int dpos, output bit to);
    int idle;
    int g;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    @(negedge clk);
    start = 1'b0;
    bc = 0; dc = 0; dpos = -1; idle = 0; g = 0;
    while (idle < 3 && g < 200) begin
      if (busy) bc++;
      else idle++;
      if (done) begin
        dc++;
        dpos = g;
      end
      @(negedge clk);
      g++;
    end
    to = (g >= 200);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0; op = 3'd0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset_n = 1'b1;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [2:0]  vo [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2};
    logic [31:0] va [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7,
                            32'd100};
    logic [31:0] vb [6] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFF9};
    logic [31:0] kh [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'd2};
    logic [31:0] kl [6] = '{32'hFFFF_FFFA, 32'h1, 32'hFFFF_FFFD, 32'h8000_0000, 32'd3,
                            32'hFFFF_FFF2};
    int bc, dc, dpos;
    bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(vo[i], va[i], vb[i], bc, dc, dpos, to);
      model_op(vo[i], va[i], vb[i]);
      checks++; if (to) begin failures++; $display("FAIL dir%0d_timeout: busy never fell", i); end
      checks++; if (bc != exp_cycles(vo[i])) begin failures++;
        $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, exp_cycles(vo[i])); end
      checks++; if (dc != 1 || dpos != bc) begin failures++;
        $display("FAIL dir%0d_done: got count %0d at %0d want 1 at %0d", i, dc, dpos, bc); end
      checks++; if (hi !== kh[i] || hi !== exp_hi) begin failures++;
        $display("FAIL dir%0d_hi: got %h want %h", i, hi, kh[i]); end
      checks++; if (lo !== kl[i] || lo !== exp_lo) begin failures++;
        $display("FAIL dir%0d_lo: got %h want %h", i, lo, kl[i]); end
    end
  endtask

  task automatic test_mt_divzero;
    int bc, dc, dpos;
    bit to;
    run_op(3'd4, 32'h1234, 32'h0, bc, dc, dpos, to);
    model_op(3'd4, 32'h1234, 32'h0);
    checks++; if (hi !== 32'h1234 || bc != 0 || dc != 0) begin failures++;
      $display("FAIL mthi: got hi %h busy %0d done %0d want 1234/0/0", hi, bc, dc); end
    run_op(3'd5, 32'h5678, 32'h0, bc, dc, dpos, to);
    model_op(3'd5, 32'h5678, 32'h0);
    checks++; if (lo !== 32'h5678 || bc != 0 || dc != 0) begin failures++;
      $display("FAIL mtlo: got lo %h busy %0d done %0d want 5678/0/0", lo, bc, dc); end
    run_op(3'd3, 32'd99, 32'h0, bc, dc, dpos, to);
    model_op(3'd3, 32'd99, 32'h0);
    checks++; if (bc != DivN || dc != 1 || dpos != DivN) begin failures++;
      $display("FAIL divu_zero_timing: got busy %0d done %0d@%0d want %0d 1@%0d",
               bc, dc, dpos, DivN, DivN); end
    checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin failures++;
      $display("FAIL divu_zero_keep: got %h/%h want 00001234/00005678", hi, lo); end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b;
    int bc, dc, dpos, ec;
    bit to;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      run_op(o, a, b, bc, dc, dpos, to);
      model_op(o, a, b);
      ec = exp_cycles(o);
      checks++; if (to || bc != ec || dc != ((o <= 3'd3) ? 1 : 0)) begin failures++;
        $display("FAIL rnd%0d_timing op %0d: got busy %0d done %0d want %0d", i, o, bc, dc, ec); end
      checks++; if (hi !== exp_hi || lo !== exp_lo) begin failures++;
        $display("FAIL rnd%0d_result op %0d a %h b %h: got %h_%h want %h_%h",
                 i, o, a, b, hi, lo, exp_hi, exp_lo); end
    end
  endtask

  task automatic test_ignore_busy;
    int g;
    @(negedge clk);
    start = 1'b1; op = 3'd0; in1 = 32'd1000; in2 = 32'd77;
    model_op(3'd0, 32'd1000, 32'd77);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd5; in1 = 32'hAAAA; in2 = 32'h0;
    @(negedge clk);
    start = 1'b0;
    g = 2;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++; if (g != MultN) begin failures++;
      $display("FAIL ignore_busy_cycles: got %0d want %0d", g, MultN); end
    repeat (3) @(negedge clk);
    checks++; if (lo !== exp_lo || hi !== exp_hi) begin failures++;
      $display("FAIL ignore_busy_result: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_back_to_back;
    int g;
    @(negedge clk);
    start = 1'b1; op = 3'd1; in1 = 32'h0001_0001; in2 = 32'h0003_0000;
    model_op(3'd1, 32'h0001_0001, 32'h0003_0000);
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++; if (done !== 1'b1 || g != MultN) begin failures++;
      $display("FAIL b2b_first: got done %b after %0d want 1 after %0d", done, g, MultN); end
    // First idle cycle: a new start must be accepted here.
    start = 1'b1; op = 3'd3; in1 = 32'd1000; in2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL b2b_accept: got busy %b want 1", busy); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin failures++;
      $display("FAIL b2b_hold: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
    model_op(3'd3, 32'd1000, 32'd7);
    g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++; if (g != DivN || hi !== exp_hi || lo !== exp_lo) begin failures++;
      $display("FAIL b2b_second: got %0d cycles %h_%h want %0d %h_%h",
               g, hi, lo, DivN, exp_hi, exp_lo); end
  endtask

  task automatic test_reset_mid_run;
    int dc, bc;
    @(negedge clk);
    start = 1'b1; op = 3'd2; in1 = 32'd5000; in2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++;
      $display("FAIL midreset_hilo: got %h_%h want 0_0", hi, lo); end
    @(negedge clk);
    reset_n = 1'b1;
    dc = 0; bc = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dc++;
      if (busy) bc++;
    end
    checks++; if (dc != 0 || bc != 0) begin failures++;
      $display("FAIL midreset_after: got done %0d busy %0d want 0 0", dc, bc); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin failures++;
      $display("FAIL midreset_nocommit: got %h_%h want 0_0", hi, lo); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_mt_divzero();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
